// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register-file geometry and the register address type.
package cpu_defs;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered count
// of how many registers are waiting on a multi-cycle producer.
module rf_scoreboard
    import cpu_defs::*;
#(
    parameter int AW    = REG_AW,
    parameter bit ZERO0 = 1'b1
) (
    input  logic                clka,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [(1<<AW)-1:0]  pending,
    output logic [AW:0]         pending_cnt,
    output logic                sb_full
);

    localparam int NREG = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(NREG - int'(ZERO0));

    logic [NREG-1:0] pending_q, pending_d;
    logic [AW:0]     cnt_q, cnt_d;

    // Retiring write clears first so a new producer on the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (we) begin
            pending_d[waddr] = 1'b0;
        end
        if (sb_set && !(ZERO0 && sb_addr == '0)) begin
            pending_d[sb_addr] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // Reset masks the outputs immediately, not only after the reset edge.
    assign pending     = rst ? '0 : pending_q;
    assign pending_cnt = rst ? '0 : cnt_q;
    assign sb_full     = (pending_cnt == FULL_CNT);

endmodule

// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file: NRD combinational read ports with same-cycle
// write bypass, one write port, and a pending-write scoreboard for stalls.
module regfile_bypass_sb
    import cpu_defs::*;
#(
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    parameter int NRD   = 2,
    parameter bit ZERO0 = 1'b1
) (
    input  logic                clka,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NRD-1:0]      rbusy,
    output logic [AW:0]         pending_cnt,
    output logic                sb_full
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0]   mem_q [NREG];
    logic [NREG-1:0] pending;
    logic            writeOk;

    assign writeOk = we && !(ZERO0 && waddr == '0);

    always_ff @(posedge clka) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (writeOk) begin
            mem_q[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .AW    (AW),
        .ZERO0 (ZERO0)
    ) u_scoreboard (
        .clka        (clka),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .sb_set      (sb_set),
        .sb_addr     (sb_addr),
        .pending     (pending),
        .pending_cnt (pending_cnt),
        .sb_full     (sb_full)
    );

    // The retiring write forwards both its data and its not-busy status.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] portData;
        logic          portBusy;

        assign addr = raddr[g*AW +: AW];

        always_comb begin
            portData = mem_q[addr];
            portBusy = pending[addr];
            if (rst || (ZERO0 && addr == '0)) begin
                portData = '0;
                portBusy = 1'b0;
            end else if (we && waddr == addr) begin
                portData = wdata;
                portBusy = 1'b0;
            end
        end

        assign rdata[g*DW +: DW] = portData;
        assign rbusy[g]          = portBusy;
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench driving a default (2 x 32-bit) and a wide (4 x 64-bit)
// register file with identical stimulus and hand-computed expectations.
module tb_regfile_bypass_sb;

    logic        clka = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        sbSet;
    logic [4:0]  sbAddr;

    logic [9:0]   raddrA;
    logic [63:0]  rdataA;
    logic [1:0]   rbusyA;
    logic [5:0]   cntA;
    logic         fullA;

    logic [19:0]  raddrB;
    logic [255:0] rdataB;
    logic [3:0]   rbusyB;
    logic [5:0]   cntB;
    logic         fullB;

    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    regfile_bypass_sb #(.DW(32), .AW(5), .NRD(2), .ZERO0(1'b1)) dutA (
        .clka(clka), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata[31:0]),
        .raddr(raddrA), .rdata(rdataA), .sb_set(sbSet), .sb_addr(sbAddr),
        .rbusy(rbusyA), .pending_cnt(cntA), .sb_full(fullA)
    );

    regfile_bypass_sb #(.DW(64), .AW(5), .NRD(4), .ZERO0(1'b1)) dutB (
        .clka(clka), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddrB), .rdata(rdataB), .sb_set(sbSet), .sb_addr(sbAddr),
        .rbusy(rbusyB), .pending_cnt(cntB), .sb_full(fullB)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of write/scoreboard inputs and points every read port at rd.
    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                                 input logic s, input logic [4:0] sa, input logic [4:0] rd);
        we = w; waddr = wa; wdata = wd; sbSet = s; sbAddr = sa;
        raddrA = {2{rd}};
        raddrB = {4{rd}};
        #1;
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 5'd5, 64'hDEADBEEF_DEADBEEF, 1'b1, 5'd5, 5'd5);
        checkOutput("rst_rdataA", {32'd0, rdataA[31:0]}, 64'd0);
        checkOutput("rst_rdataB", rdataB[191:128], 64'd0);
        checkOutput("rst_cnt", {58'd0, cntA}, 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5);
        checkOutput("r5_after_rst_A", {32'd0, rdataA[31:0]}, 64'd0);
        checkOutput("r5_after_rst_B", rdataB[255:192], 64'd0);
        checkOutput("busy_after_rst", {58'd0, rbusyA, rbusyB}, 64'd0);
        checkOutput("cnt_after_rst", {52'd0, cntA, cntB}, 64'd0);

        applyStimulus(1'b1, 5'd7, 64'h0BADF00D_12345678, 1'b0, 5'd0, 5'd7);
        checkOutput("bypass_A", {32'd0, rdataA[31:0]}, 64'h12345678);
        checkOutput("bypass_B", rdataB[127:64], 64'h0BADF00D_12345678);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7);
        checkOutput("stored_A", {32'd0, rdataA[63:32]}, 64'h12345678);
        checkOutput("stored_B", rdataB[255:192], 64'h0BADF00D_12345678);

        applyStimulus(1'b1, 5'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 5'd0, 5'd0);
        checkOutput("r0_bypass_A", {32'd0, rdataA[31:0]}, 64'd0);
        checkOutput("r0_busy", {58'd0, rbusyA, rbusyB}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("r0_read_B", rdataB[63:0], 64'd0);
        checkOutput("r0_cnt", {52'd0, cntA, cntB}, 64'd0);

        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9);
        checkOutput("busy_before_set", {58'd0, rbusyA, rbusyB}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9);
        raddrB[9:5] = 5'd7;
        #1;
        checkOutput("r9_busy", {58'd0, rbusyA, rbusyB}, {58'd0, 2'b11, 4'b1101});
        checkOutput("r9_cnt", {52'd0, cntA, cntB}, {52'd0, 6'd1, 6'd1});
        checkOutput("indep_port_B", rdataB[127:64], 64'h0BADF00D_12345678);
        applyStimulus(1'b1, 5'd9, 64'h0000_00A5, 1'b0, 5'd0, 5'd9);
        checkOutput("r9_wb_busy", {58'd0, rbusyA, rbusyB}, 64'd0);
        checkOutput("r9_wb_data", {32'd0, rdataA[31:0]}, 64'hA5);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9);
        checkOutput("r9_cnt_clear", {52'd0, cntA, cntB}, 64'd0);
        checkOutput("r9_data_B", rdataB[191:128], 64'hA5);

        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3);
        tick();
        applyStimulus(1'b1, 5'd3, 64'h1111_2222_3333_0077, 1'b1, 5'd3, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3);
        checkOutput("coll_data_A", {32'd0, rdataA[31:0]}, 64'h3333_0077);
        checkOutput("coll_data_B", rdataB[63:0], 64'h1111_2222_3333_0077);
        checkOutput("coll_busy", {58'd0, rbusyA, rbusyB}, {58'd0, 2'b11, 4'b1111});
        checkOutput("coll_cnt", {52'd0, cntA, cntB}, {52'd0, 6'd1, 6'd1});
        applyStimulus(1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31);
        checkOutput("coll_retire_cnt", {52'd0, cntA, cntB}, 64'd0);

        for (int i = 1; i <= 31; i++) begin
            applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 5'd31);
            tick();
            if (i == 30) begin
                checkOutput("cnt30_notfull", {52'd0, cntA, 5'd0, fullA}, {52'd0, 6'd30, 6'd0});
            end
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd31);
        checkOutput("full_cnt", {52'd0, cntA, cntB}, {52'd0, 6'd31, 6'd31});
        checkOutput("full_flag", {62'd0, fullA, fullB}, 64'd3);
        checkOutput("full_busy", {58'd0, rbusyA, rbusyB}, {58'd0, 6'b111111});
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31);
        checkOutput("full_redundant_set", {52'd0, cntA, cntB}, {52'd0, 6'd31, 6'd31});
        rst = 1'b1;
        #1;
        checkOutput("rst_held_cnt", {52'd0, cntA, cntB}, 64'd0);
        checkOutput("rst_held_busy", {58'd0, rbusyA, rbusyB}, 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31);
        checkOutput("midrst_cnt", {52'd0, cntA, cntB}, 64'd0);
        checkOutput("midrst_full", {62'd0, fullA, fullB}, 64'd0);
        checkOutput("midrst_busy", {58'd0, rbusyA, rbusyB}, 64'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7);
        checkOutput("midrst_r7_A", {32'd0, rdataA[31:0]}, 64'd0);
        checkOutput("midrst_r7_B", rdataB[255:192], 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
